// File: rtl/stack_controller.sv
// Command front end for the hardware stack: accepts push/pop commands, guards
// full/empty, drives the stack memory and stack_pointer strobes, returns pops.
module stack_controller #(
    parameter int ADDR_WIDTH = 20,
    parameter int DATA_WIDTH = 16,
    parameter int DEPTH      = 1024,
    localparam int DEPTH_W   = $clog2(DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_op,
    input  logic [DATA_WIDTH-1:0] cmd_data,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_data,
    output logic                  sp_push,
    output logic                  sp_pop,
    input  logic [ADDR_WIDTH-1:0] sp_addr,
    output logic                  mem_we,
    output logic                  mem_re,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic [DEPTH_W-1:0]    depth,
    output logic                  full,
    output logic                  empty,
    output logic                  ovf_err,
    output logic                  udf_err,
    output logic [2:0]            state_dbg
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_WRITE = 3'd1,
        S_READ  = 3'd2,
        S_WAIT  = 3'd3,
        S_RESP  = 3'd4
    } state_t;

    state_t                state;
    state_t                state_next;
    logic [DATA_WIDTH-1:0] data_q;
    logic                  cmd_fire;

    // Handshakes: a transfer happens on a rising edge where valid & ready are
    // both high; valid and the payload hold until then and ready never waits
    // on valid. cmd_ready is high only in IDLE, so one command is in flight.
    assign cmd_fire  = cmd_valid & cmd_ready;
    assign full      = (depth == DEPTH_W'(DEPTH));
    assign empty     = (depth == '0);
    assign state_dbg = state;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= S_IDLE;
            depth    <= '0;
            data_q   <= '0;
            rsp_data <= '0;
            ovf_err  <= 1'b0;
            udf_err  <= 1'b0;
        end else begin
            state   <= state_next;
            ovf_err <= cmd_fire & ~cmd_op & full;
            udf_err <= cmd_fire & cmd_op & empty;
            if (cmd_fire) begin
                data_q <= cmd_data;
            end
            if (state == S_WRITE) begin
                depth <= depth + DEPTH_W'(1);
            end else if (state == S_READ) begin
                depth <= depth - DEPTH_W'(1);
            end
            // Memory read data arrives the cycle after mem_re, i.e. in WAIT.
            if (state == S_WAIT) begin
                rsp_data <= mem_rdata;
            end
        end
    end

    always_comb begin
        state_next = state;
        cmd_ready  = 1'b0;
        rsp_valid  = 1'b0;
        sp_push    = 1'b0;
        sp_pop     = 1'b0;
        mem_we     = 1'b0;
        mem_re     = 1'b0;
        mem_addr   = '0;
        mem_wdata  = '0;
        case (state)
            S_IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    if (!cmd_op && !full) begin
                        state_next = S_WRITE;
                    end else if (cmd_op && !empty) begin
                        state_next = S_READ;
                    end
                end
            end
            S_WRITE: begin
                mem_we     = 1'b1;
                mem_addr   = sp_addr;
                mem_wdata  = data_q;
                sp_push    = 1'b1;
                state_next = S_IDLE;
            end
            S_READ: begin
                // sp_addr is the next free slot; the top entry sits just below.
                mem_re     = 1'b1;
                mem_addr   = sp_addr - ADDR_WIDTH'(1);
                sp_pop     = 1'b1;
                state_next = S_WAIT;
            end
            S_WAIT: begin
                state_next = S_RESP;
            end
            S_RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    state_next = S_IDLE;
                end
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_stack_controller.sv
// Directed bench for stack_controller with a behavioural stack_pointer and
// memory; expected data comes from a LIFO scoreboard and hand-computed addresses.
module tb_stack_controller;

    localparam int AW    = 20;
    localparam int DW    = 16;
    localparam int DEPTH = 4;
    localparam logic [AW-1:0] BASE = 20'h00100;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          cmd_valid;
    logic          cmd_ready;
    logic          cmd_op;
    logic [DW-1:0] cmd_data;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [DW-1:0] rsp_data;
    logic          sp_push;
    logic          sp_pop;
    logic [AW-1:0] sp_addr;
    logic          mem_we;
    logic          mem_re;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata = '0;
    logic [2:0]    depth;
    logic          full;
    logic          empty;
    logic          ovf_err;
    logic          udf_err;
    logic [2:0]    state_dbg;

    logic [DW-1:0] mem [0:255];
    logic [DW-1:0] exp_q[$];
    int            m_depth;
    int            n_checks;
    int            n_fail;
    int            both_cnt;
    int            rsp_after_rst;

    stack_controller #(
        .ADDR_WIDTH(AW),
        .DATA_WIDTH(DW),
        .DEPTH     (DEPTH)
    ) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .cmd_op   (cmd_op),
        .cmd_data (cmd_data),
        .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready),
        .rsp_data (rsp_data),
        .sp_push  (sp_push),
        .sp_pop   (sp_pop),
        .sp_addr  (sp_addr),
        .mem_we   (mem_we),
        .mem_re   (mem_re),
        .mem_addr (mem_addr),
        .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata),
        .depth    (depth),
        .full     (full),
        .empty    (empty),
        .ovf_err  (ovf_err),
        .udf_err  (udf_err),
        .state_dbg(state_dbg)
    );

    // ---------------- clock / environment models ----------------
    always #5 clk = ~clk;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sp_addr <= BASE;
        end else if (sp_push) begin
            sp_addr <= sp_addr + 20'd1;
        end else if (sp_pop) begin
            sp_addr <= sp_addr - 20'd1;
        end
    end

    always @(posedge clk) begin
        if (mem_we) mem[mem_addr[7:0]] <= mem_wdata;
        if (mem_re) mem_rdata <= mem[mem_addr[7:0]];
        if (sp_push && sp_pop) both_cnt++;
    end

    initial begin
        #300000;
        $display("FAIL global_timeout: simulation did not finish, required end by 300000");
        $fatal(1);
    end

    // ---------------- checking ----------------
    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // ---------------- drivers ----------------
    task automatic wait_idle();
        int i;
        for (i = 0; i < 20; i++) begin
            if (cmd_ready) break;
            @(negedge clk);
        end
        if (i == 20) check_eq("ready_timeout", 32'(cmd_ready), 32'd1);
    endtask

    task automatic push_cmd(input logic [DW-1:0] d);
        wait_idle();
        cmd_valid = 1'b1;
        cmd_op    = 1'b0;
        cmd_data  = d;
        @(negedge clk);
        cmd_valid = 1'b0;
        cmd_data  = '0;
        if (m_depth == DEPTH) begin
            check_eq("ovf_pulse", 32'(ovf_err), 32'd1);
            check_eq("ovf_no_we", 32'(mem_we), 32'd0);
            check_eq("ovf_no_sp_push", 32'(sp_push), 32'd0);
            check_eq("ovf_ready", 32'(cmd_ready), 32'd1);
            @(negedge clk);
            check_eq("ovf_pulse_end", 32'(ovf_err), 32'd0);
            check_eq("ovf_depth", 32'(depth), 32'(DEPTH));
        end else begin
            check_eq("push_we", 32'(mem_we), 32'd1);
            check_eq("push_addr", 32'(mem_addr), 32'(BASE) + 32'(m_depth));
            check_eq("push_wdata", 32'(mem_wdata), 32'(d));
            check_eq("push_sp", 32'(sp_push), 32'd1);
            check_eq("push_busy", 32'(cmd_ready), 32'd0);
            exp_q.push_back(d);
            m_depth++;
            @(negedge clk);
            check_eq("push_idle", 32'(cmd_ready), 32'd1);
            check_eq("push_depth", 32'(depth), 32'(m_depth));
        end
    endtask

    task automatic pop_cmd(input int hold);
        logic [DW-1:0] exp;
        wait_idle();
        cmd_valid = 1'b1;
        cmd_op    = 1'b1;
        rsp_ready = 1'b0;
        @(negedge clk);
        cmd_valid = 1'b0;
        if (m_depth == 0) begin
            check_eq("udf_pulse", 32'(udf_err), 32'd1);
            check_eq("udf_no_re", 32'(mem_re), 32'd0);
            check_eq("udf_no_sp_pop", 32'(sp_pop), 32'd0);
            check_eq("udf_ready", 32'(cmd_ready), 32'd1);
            @(negedge clk);
            check_eq("udf_pulse_end", 32'(udf_err), 32'd0);
            check_eq("udf_depth", 32'(depth), 32'd0);
        end else begin
            check_eq("pop_re", 32'(mem_re), 32'd1);
            check_eq("pop_addr", 32'(mem_addr), 32'(BASE) + 32'(m_depth) - 32'd1);
            check_eq("pop_sp", 32'(sp_pop), 32'd1);
            @(negedge clk);
            check_eq("pop_wait_no_valid", 32'(rsp_valid), 32'd0);
            @(negedge clk);
            exp = exp_q.pop_back();
            m_depth--;
            check_eq("pop_valid", 32'(rsp_valid), 32'd1);
            check_eq("pop_data", 32'(rsp_data), 32'(exp));
            check_eq("pop_depth", 32'(depth), 32'(m_depth));
            for (int i = 0; i < hold; i++) begin
                @(negedge clk);
                check_eq("bp_valid", 32'(rsp_valid), 32'd1);
                check_eq("bp_data", 32'(rsp_data), 32'(exp));
                check_eq("bp_ready", 32'(cmd_ready), 32'd0);
            end
            rsp_ready = 1'b1;
            @(negedge clk);
            rsp_ready = 1'b0;
            check_eq("pop_done_valid", 32'(rsp_valid), 32'd0);
            check_eq("pop_done_idle", 32'(cmd_ready), 32'd1);
            check_eq("pop_data_kept", 32'(rsp_data), 32'(exp));
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        n_checks      = 0;
        n_fail        = 0;
        both_cnt      = 0;
        rsp_after_rst = 0;
        m_depth       = 0;
        reset_n       = 1'b0;
        cmd_valid     = 1'b0;
        cmd_op        = 1'b0;
        cmd_data      = '0;
        rsp_ready     = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);

        check_eq("rst_ready", 32'(cmd_ready), 32'd1);
        check_eq("rst_empty", 32'(empty), 32'd1);
        check_eq("rst_full", 32'(full), 32'd0);
        check_eq("rst_depth", 32'(depth), 32'd0);
        check_eq("rst_strobes", {26'd0, mem_we, mem_re, sp_push, sp_pop, ovf_err, udf_err}, 32'd0);
        check_eq("rst_rsp", {15'd0, rsp_valid, rsp_data}, 32'd0);
        check_eq("rst_sp_addr", 32'(sp_addr), 32'(BASE));
        check_eq("rst_state", 32'(state_dbg), 32'd0);

        pop_cmd(0);                       // underflow on empty

        push_cmd(16'h1111);               // LIFO order
        push_cmd(16'h2222);
        push_cmd(16'h3333);
        pop_cmd(0);
        pop_cmd(0);
        pop_cmd(0);
        check_eq("lifo_empty", 32'(empty), 32'd1);

        push_cmd(16'hA001);               // overflow at DEPTH = 4
        push_cmd(16'hA002);
        push_cmd(16'hA003);
        check_eq("not_full_3", 32'(full), 32'd0);
        push_cmd(16'hA004);
        check_eq("full_4", 32'(full), 32'd1);
        push_cmd(16'hA005);
        check_eq("full_after_ovf", 32'(full), 32'd1);

        pop_cmd(5);                       // backpressure
        pop_cmd(1);
        pop_cmd(0);
        pop_cmd(0);
        pop_cmd(0);                       // underflow after drain

        push_cmd(16'h5A5A);               // reset during WAIT
        wait_idle();
        cmd_valid = 1'b1;
        cmd_op    = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
        @(negedge clk);
        check_eq("mid_state_wait", 32'(state_dbg), 32'd3);
        reset_n = 1'b0;
        #1;
        check_eq("mid_rst_idle", 32'(state_dbg), 32'd0);
        check_eq("mid_rst_valid", 32'(rsp_valid), 32'd0);
        check_eq("mid_rst_depth", 32'(depth), 32'd0);
        check_eq("mid_rst_ready", 32'(cmd_ready), 32'd1);
        exp_q.delete();
        m_depth = 0;
        @(negedge clk);
        reset_n   = 1'b1;
        rsp_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (rsp_valid) rsp_after_rst++;
        end
        rsp_ready = 1'b0;
        check_eq("no_rsp_after_rst", 32'(rsp_after_rst), 32'd0);
        check_eq("post_rst_empty", 32'(empty), 32'd1);

        push_cmd(16'hBEEF);               // still functional after reset
        pop_cmd(0);

        check_eq("sp_strobes_exclusive", 32'(both_cnt), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
